// File: rtl/state_ram_arbiter_if.sv
// Request/response bus between ALU requesters and the state RAM arbiter.
// The master side (requesters plus response consumer) drives the requests and resp_ready.
// The slave side (the arbiter) returns the grant and the response.
interface state_ram_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_wr;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic                          resp_valid;
  logic                          resp_ready;
  logic [ID_W-1:0]               resp_id;
  logic [DATA_WIDTH-1:0]         resp_data;
  logic                          resp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, resp_err
  );
endinterface

// File: rtl/state_ram_arbiter.sv
// Round-robin arbiter giving NUM_REQ ALU requesters access to a single-port state RAM.
// It performs one transaction at a time: IDLE -> ACCESS -> WAIT -> RESP.
// Tenant offsets are translated through page_tbl ({addr_len, base_addr}) and range-checked.
// Optional feature macro STATE_RAM_CFG_PORT_EN enables the control-plane write port on cfg_*.
// The cfg write takes priority over requesters in IDLE.
// Assumes ADDR_WIDTH <= 8 (the base_addr field is 8 bits).
module state_ram_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  state_ram_arbiter_if.slave    bus,
  input  logic [15:0]           page_tbl,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_data
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t                state;
  logic [ID_W-1:0]       last_grant;
  logic                  txn_wr;
  logic                  txn_err;
  logic                  ram_we_q;
  logic                  resp_valid_q;
  logic [ID_W-1:0]       resp_id_q;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic                  resp_err_q;

  logic [NUM_REQ-1:0]    grant_c;
  logic [ID_W-1:0]       grant_id_c;
  logic [ID_W-1:0]       idx_c;
  logic                  found_c;
  logic                  cfg_take_c;
  logic                  accept_c;
  logic                  sel_wr_c;
  logic [ADDR_WIDTH-1:0] sel_off_c;
  logic [DATA_WIDTH-1:0] sel_wdata_c;
  logic                  sel_err_c;
  logic [ADDR_WIDTH-1:0] sel_phys_c;
  logic                  pg_unused;

  // The upper base_addr bits are not used in the address translation.
  assign pg_unused = ^page_tbl;

`ifdef STATE_RAM_CFG_PORT_EN
  // A control-plane write wins over every requester while idle.
  assign cfg_ready  = (state == IDLE) & rst_n;
  assign cfg_take_c = cfg_ready & cfg_valid;
`else
  logic cfg_unused;
  assign cfg_ready  = 1'b0;
  assign cfg_take_c = 1'b0;
  assign cfg_unused = ^{cfg_valid, cfg_addr, cfg_data};
`endif

  // Round-robin winner: first valid requester after last_grant, with wrap.
  always_comb begin
    grant_c    = '0;
    grant_id_c = '0;
    idx_c      = '0;
    found_c    = 1'b0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      idx_c = ID_W'((int'(last_grant) + k) % int'(NUM_REQ));
      if (!found_c && bus.req_valid[idx_c]) begin
        found_c    = 1'b1;
        grant_id_c = idx_c;
      end
    end
    if (found_c) grant_c[grant_id_c] = 1'b1;
  end

  // Mux the winning requester's payload.
  always_comb begin
    sel_wr_c    = 1'b0;
    sel_off_c   = '0;
    sel_wdata_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_id_c == ID_W'(i)) begin
        sel_wr_c    = bus.req_wr[i];
        sel_off_c   = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata_c = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    sel_err_c  = 32'(sel_off_c) > 32'(page_tbl[15:8]);
    sel_phys_c = page_tbl[ADDR_WIDTH-1:0] + sel_off_c;
  end

  assign bus.req_ready = (state == IDLE && !cfg_take_c) ? grant_c : '0;
  assign accept_c      = (state == IDLE) && !cfg_take_c && found_c;

  // Gate the write strobe with reset so a reset landing in ACCESS never reaches the RAM.
  assign ram_we         = ram_we_q & rst_n;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;

  // Transaction FSM with registered RAM and response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= ID_W'(NUM_REQ - 1);
      txn_wr       <= 1'b0;
      txn_err      <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr     <= '0;
      ram_din      <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      ram_we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_take_c) begin
            ram_we_q <= 1'b1;
            ram_addr <= cfg_addr;
            ram_din  <= cfg_data;
          end else if (accept_c) begin
            resp_id_q  <= grant_id_c;
            last_grant <= grant_id_c;
            txn_wr     <= sel_wr_c;
            txn_err    <= sel_err_c;
            ram_addr   <= sel_phys_c;
            ram_din    <= sel_wdata_c;
            ram_we_q   <= sel_wr_c & ~sel_err_c;
            state      <= ACCESS;
          end
        end
        ACCESS: state <= WAIT;
        WAIT: begin
          resp_data_q  <= (!txn_wr && !txn_err) ? ram_dout : '0;
          resp_err_q   <= txn_err;
          resp_valid_q <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_state_ram_arbiter.sv
// Bench for state_ram_arbiter: RAM model plus response/write scoreboards fed by scenario tasks.
module tb_state_ram_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DW      = 32;
  localparam int unsigned AW      = 5;

  typedef struct packed { logic [1:0] id; logic [DW-1:0] data; logic err; } resp_t;
  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   page_tbl;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;

  logic          ram_clear = 1'b1;
  logic          mon_en = 1'b0;
  logic [DW-1:0] mem [32];
  logic [DW-1:0] ref_mem [32];
  resp_t         resp_q [$];
  wr_t           wr_q [$];
  int            checks = 0;
  int            errors = 0;

  state_ram_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  state_ram_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .page_tbl (page_tbl),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data)
  );

  always #5 clk = ~clk;

  // Single-port RAM, read-first, one cycle read latency.
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA5A50000 ^ 32'(i * 7);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  // Scoreboard: compare responses and RAM writes against queued expectations.
  always @(negedge clk) begin
    resp_t er;
    wr_t   ew;
    if (mon_en) begin
      if (bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
        checks++;
        if (resp_q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: id=%0d data=%h err=%b, required no response",
                   bus.resp_id, bus.resp_data, bus.resp_err);
        end else begin
          er = resp_q.pop_front();
          if (bus.resp_id !== er.id || bus.resp_data !== er.data || bus.resp_err !== er.err) begin
            errors++;
            $display("FAIL resp: id=%0d data=%h err=%b, required id=%0d data=%h err=%b",
                     bus.resp_id, bus.resp_data, bus.resp_err, er.id, er.data, er.err);
          end
        end
      end
      if (ram_we === 1'b1) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL ram_we_unexpected: addr=%0d din=%h, required no write", ram_addr, ram_din);
        end else begin
          ew = wr_q.pop_front();
          if (ram_addr !== ew.addr || ram_din !== ew.data) begin
            errors++;
            $display("FAIL ram_write: addr=%0d din=%h, required addr=%0d din=%h",
                     ram_addr, ram_din, ew.addr, ew.data);
          end
        end
      end
    end
  end

  task automatic start_req(input int id, input logic wr, input logic [AW-1:0] off,
                           input logic [DW-1:0] wd);
    bus.req_wr[id]               = wr;
    bus.req_addr[id*AW +: AW]    = off;
    bus.req_wdata[id*DW +: DW]   = wd;
    bus.req_valid[id]            = 1'b1;
  endtask

  // Wait for the grant, queue the predicted outcome, drop valid after accept, check ACCESS address.
  task automatic expect_grant(input int id, input logic wr, input logic [AW-1:0] off,
                              input logic [DW-1:0] wd);
    logic [AW-1:0] phys;
    logic          err;
    logic [3:0]    oh;
    resp_t         r;
    wr_t           w;
    int            n;
    n  = 0;
    oh = 4'b0001 << id;
    @(negedge clk);
    while (bus.req_ready === 4'b0000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.req_ready !== oh) begin
      errors++;
      $display("FAIL grant_%0d: req_ready=%b, required %b", id, bus.req_ready, oh);
    end
    err    = {3'b000, off} > page_tbl[15:8];
    phys   = page_tbl[AW-1:0] + off;
    r.id   = 2'(id);
    r.err  = err;
    r.data = (!wr && !err) ? ref_mem[phys] : '0;
    if (wr && !err) begin
      w.addr = phys;
      w.data = wd;
      wr_q.push_back(w);
      ref_mem[phys] = wd;
    end
    resp_q.push_back(r);
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_addr !== phys) begin
      errors++;
      $display("FAIL access_addr_%0d: ram_addr=%0d, required %0d", id, ram_addr, phys);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((resp_q.size() != 0 || wr_q.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (resp_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending resp=%0d wr=%0d, required 0 0", resp_q.size(), wr_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ram_clear = 1'b1;
    bus.req_valid = '0; bus.req_wr = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.resp_ready = 1'b1;
    page_tbl = '0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'hA5A50000 ^ 32'(i * 7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.resp_valid, bus.resp_err, bus.resp_id} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_resp: valid=%b err=%b id=%0d, required 0 0 0",
               bus.resp_valid, bus.resp_err, bus.resp_id);
    end
    checks++;
    if (bus.resp_data !== '0 || ram_din !== '0) begin
      errors++;
      $display("FAIL reset_data: resp_data=%h ram_din=%h, required 0 0", bus.resp_data, ram_din);
    end
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== '0) begin
      errors++;
      $display("FAIL reset_ram: we=%b addr=%0d, required 0 0", ram_we, ram_addr);
    end
    checks++;
    if (cfg_ready !== 1'b0 || bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: cfg_ready=%b req_ready=%b, required 0 0000", cfg_ready, bus.req_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; ram_clear = 1'b0; mon_en = 1'b1;
    @(negedge clk);
    checks++;
`ifdef STATE_RAM_CFG_PORT_EN
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_cfg_ready: cfg_ready=%b, required 1", cfg_ready);
    end
`else
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_cfg_ready: cfg_ready=%b, required 0", cfg_ready);
    end
`endif
  endtask

  task automatic test_round_robin();
    resp_t      r;
    logic [3:0] exp_oh;
    page_tbl = {8'd31, 8'd0};
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) start_req(i, 1'b0, AW'(3 * i + 1), '0);
    @(negedge clk);
    for (int t = 0; t < 5; t++) begin
      int id = t % 4;
      exp_oh = 4'b0001 << id;
      checks++;
      if (bus.req_ready !== exp_oh) begin
        errors++;
        $display("FAIL rr_grant_%0d: req_ready=%b, required %b", t, bus.req_ready, exp_oh);
      end
      r.id = 2'(id); r.err = 1'b0; r.data = ref_mem[3 * id + 1];
      resp_q.push_back(r);
      if (t == 4) begin
        @(posedge clk); #1;
        bus.req_valid = '0;
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL rr_early_%0d: resp_valid=%b, required 0", t, bus.resp_valid);
      end
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_latency_%0d: resp_valid=%b, required 1", t, bus.resp_valid);
      end
      if (t < 4) @(negedge clk);
    end
    drain();
  endtask

  task automatic test_store_load();
    page_tbl = {8'd4, 8'd8};
    @(posedge clk); #1;
    start_req(2, 1'b1, 5'd3, 32'hDEADBEEF);
    expect_grant(2, 1'b1, 5'd3, 32'hDEADBEEF);
    drain();
    @(posedge clk); #1;
    start_req(2, 1'b0, 5'd3, '0);
    expect_grant(2, 1'b0, 5'd3, '0);
    drain();
  endtask

  task automatic test_wrap_err();
    page_tbl = {8'd4, 8'd30};
    @(posedge clk); #1;
    start_req(0, 1'b0, 5'd4, '0);
    expect_grant(0, 1'b0, 5'd4, '0);
    drain();
    @(posedge clk); #1;
    start_req(0, 1'b0, 5'd5, '0);
    expect_grant(0, 1'b0, 5'd5, '0);
    drain();
    @(posedge clk); #1;
    start_req(1, 1'b1, 5'd5, 32'h12345678);
    expect_grant(1, 1'b1, 5'd5, 32'h12345678);
    drain();
  endtask

  task automatic test_backpressure();
    resp_t er;
    int    n = 0;
    page_tbl = {8'd31, 8'd0};
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    start_req(1, 1'b0, 5'd9, '0);
    expect_grant(1, 1'b0, 5'd9, '0);
    @(posedge clk); #1;
    start_req(3, 1'b0, 5'd12, '0);
    while (bus.resp_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    er = (resp_q.size() != 0) ? resp_q[0] : '0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_id !== er.id || bus.resp_data !== er.data ||
          bus.resp_err !== er.err) begin
        errors++;
        $display("FAIL hold_%0d: valid=%b id=%0d data=%h err=%b, required 1 %0d %h %b",
                 c, bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_err, er.id, er.data, er.err);
      end
      checks++;
      if (bus.req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL hold_grant_%0d: req_ready=%b, required 0000", c, bus.req_ready);
      end
      if (c < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    expect_grant(3, 1'b0, 5'd12, '0);
    drain();
  endtask

  task automatic test_mid_reset();
    int n = 0;
    page_tbl = {8'd31, 8'd0};
    @(posedge clk); #1;
    start_req(0, 1'b1, 5'd1, 32'hCAFEF00D);
    @(negedge clk);
    while (bus.req_ready === 4'b0000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid_grant: req_ready=%b, required 0001", bus.req_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_we: ram_we=%b, required 0", ram_we);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_resp: resp_valid=%b, required 0", bus.resp_valid);
    end
    @(posedge clk); #1;
    start_req(3, 1'b0, 5'd2, '0);
    start_req(0, 1'b0, 5'd1, '0);
    expect_grant(0, 1'b0, 5'd1, '0);
    expect_grant(3, 1'b0, 5'd2, '0);
    drain();
  endtask

  task automatic test_cfg();
    wr_t w;
    page_tbl = {8'd31, 8'd0};
`ifdef STATE_RAM_CFG_PORT_EN
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_addr = 5'd7; cfg_data = 32'h55;
    start_req(1, 1'b0, 5'd7, '0);
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b1 || bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL cfg_priority: cfg_ready=%b req_ready=%b, required 1 0000", cfg_ready, bus.req_ready);
    end
    w.addr = 5'd7; w.data = 32'h55;
    wr_q.push_back(w);
    ref_mem[7] = 32'h55;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    expect_grant(1, 1'b0, 5'd7, '0);
    drain();
`else
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_addr = 5'd7; cfg_data = 32'h55;
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL cfg_disabled: cfg_ready=%b, required 0", cfg_ready);
    end
    @(posedge clk); #1;
    start_req(1, 1'b0, 5'd7, '0);
    expect_grant(1, 1'b0, 5'd7, '0);
    cfg_valid = 1'b0;
    drain();
`endif
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_store_load();
    test_wrap_err();
    test_backpressure();
    test_mid_reset();
    test_cfg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
